fb_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit for the Firebird pipeline's execute stage, parametrised in operand width. It consumes the eight one-hot M-extension operation bits from the ALU control decode plus two register operands. It computes the result over multiple cycles and returns it through a valid/ready handshake. The pipeline stalls the execute stage on `busy` and can abort an operation in flight with `flush`.

---
 rtl/fb_muldiv_if.sv | 26 ++
 rtl/fb_muldiv.sv | 167 ++++++++++++++++
 tb/tb_fb_muldiv.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fb_muldiv_if.sv
// Request/response bundle between the execute stage and the iterative M-extension unit.
// The unit takes the slave side; the pipeline (or a bench) drives the master side.
interface fb_muldiv_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result_o;
    logic            busy;

    modport master (
        output in_valid, op_i, rs1_i, rs2_i, flush, out_ready,
        input  in_ready, out_valid, result_o, busy
    );

    modport slave (
        input  in_valid, op_i, rs1_i, rs2_i, flush, out_ready,
        output in_ready, out_valid, result_o, busy
    );
endinterface

// File: rtl/fb_muldiv.sv
// Iterative RV32M multiply/divide: one bit per cycle, XLEN+2 cycles, 1 cycle for div special cases.
// Result held in DONE until out_ready; flush aborts. FB_MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
module fb_muldiv #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    fb_muldiv_if.slave   bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [XLEN-1:0] ONES = '1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic              neg_q, neg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Bit index of the selected op: 7 mul .. 0 remu; the highest set bit wins.
    logic [2:0]      op_sel;
    logic            is_mul_in, is_rem_in, s1_signed, s2_signed, neg1, neg2, neg_in;
    logic            accept, div_zero, div_ovf;
    logic [XLEN-1:0] mag1, mag2, special_res;

    always_comb begin
        op_sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bus.op_i[i]) op_sel = 3'(i);
        end
    end

    assign is_mul_in = op_sel[2];
    assign is_rem_in = (op_sel == 3'd1) || (op_sel == 3'd0);
    assign s1_signed = (op_sel == 3'd6) || (op_sel == 3'd5) || (op_sel == 3'd3) || (op_sel == 3'd1);
    assign s2_signed = (op_sel == 3'd6) || (op_sel == 3'd3) || (op_sel == 3'd1);
    assign neg1      = s1_signed & bus.rs1_i[XLEN-1];
    assign neg2      = s2_signed & bus.rs2_i[XLEN-1];
    assign mag1      = neg1 ? -bus.rs1_i : bus.rs1_i;
    assign mag2      = neg2 ? -bus.rs2_i : bus.rs2_i;
    // Remainder follows the dividend sign; quotient and products follow the xor.
    assign neg_in    = is_rem_in ? neg1 : (neg1 ^ neg2);

    assign accept      = bus.in_valid && (state_q == S_IDLE) && (|bus.op_i);
    assign div_zero    = !is_mul_in && (bus.rs2_i == '0);
    assign div_ovf     = ((op_sel == 3'd3) || (op_sel == 3'd1)) &&
                         (bus.rs1_i == SMIN) && (bus.rs2_i == ONES);
    assign special_res = div_zero ? (is_rem_in ? bus.rs1_i : ONES)
                                  : (is_rem_in ? '0 : bus.rs1_i);

`ifdef FB_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fprod_mag, fprod;
    assign fprod_mag = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
    assign fprod     = neg_in ? -fprod_mag : fprod_mag;
`endif

    // Divide keeps {remainder, quotient-in-progress}; multiply keeps {high, multiplier-being-shifted}.
    logic [XLEN:0]     div_top, div_diff, mul_sum;
    logic              div_ge;
    logic [2*XLEN-1:0] div_step, mul_step;

    assign div_top  = acc_q[2*XLEN-1:XLEN-1];
    assign div_ge   = div_top >= {1'b0, opnd_q};
    assign div_diff = div_top - {1'b0, opnd_q};
    assign div_step = {div_ge ? div_diff[XLEN-1:0] : div_top[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (sel_q)
            3'd7:                fix_res = prod_fix[XLEN-1:0];
            3'd6, 3'd5, 3'd4:    fix_res = prod_fix[2*XLEN-1:XLEN];
            3'd3, 3'd2:          fix_res = quo_fix;
            default:             fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        sel_d = op_sel;
                        neg_d = neg_in;
                        cnt_d = CNT_W'(XLEN);
                        if (div_zero || div_ovf) begin
                            result_d = special_res;
                            state_d  = S_DONE;
                        end
`ifdef FB_MULDIV_FAST_MUL_EN
                        else if (is_mul_in) begin
                            result_d = (op_sel == 3'd7) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
                            state_d  = S_DONE;
                        end
`endif
                        else begin
                            opnd_d  = is_mul_in ? mag1 : mag2;
                            acc_d   = {{XLEN{1'b0}}, is_mul_in ? mag2 : mag1};
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_d = sel_q[2] ? mul_step : div_step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_FIX;
                end
                S_FIX: begin
                    result_d = fix_res;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result_o  = result_q;
endmodule

// File: tb/tb_fb_muldiv.sv
// Scoreboard bench for fb_muldiv: the driver queues expected results and latencies,
// a monitor pops and compares them whenever a result is consumed.
module tb_fb_muldiv;
    localparam logic [7:0] OP_MUL = 8'h80, OP_MULH = 8'h40, OP_MULHSU = 8'h20, OP_MULHU = 8'h10;
    localparam logic [7:0] OP_DIV = 8'h08, OP_DIVU = 8'h04, OP_REM = 8'h02, OP_REMU = 8'h01;
    localparam int DIV_LAT = 34;
`ifdef FB_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc_cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    fb_muldiv_if #(.XLEN(32)) bus ();
    fb_muldiv #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Present a request and return #1 after the edge that accepts it.
    task automatic start(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, output int acc_cyc);
        int t;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op_i     = op;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        t = 0;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) timeout("accept");
        @(posedge clk);
        #1;
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
        bus.op_i     = 8'h00;
    endtask

    task automatic issue(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int lat);
        exp_t e;
        int   ac;
        start(op, a, b, ac);
        e.res = res; e.lat = lat; e.acc_cyc = ac; e.name = name;
        sb.push_back(e);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb.size(), 0);
    endtask

    // Monitor: records the first cycle out_valid is seen and checks on consumption.
    initial begin : monitor
        bit seen;
        int first;
        exp_t e;
        seen = 0;
        first = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                seen = 0;
            end else begin
                if (bus.out_valid && !seen) begin
                    seen  = 1;
                    first = cyc;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        timeout("unexpected_result");
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_res"}, bus.result_o, e.res);
                        check({e.name, "_lat"}, first - e.acc_cyc + 1, e.lat);
                    end
                    seen = 0;
                end
            end
        end
    end

    initial begin : driver
        int t;
        int ac;
        bus.in_valid  = 1'b0;
        bus.op_i      = 8'h00;
        bus.rs1_i     = '0;
        bus.rs2_i     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_result", bus.result_o, 0);
        rst = 1'b0;

        // op_i == 0 must not be accepted.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op_i     = 8'h00;
        repeat (3) @(negedge clk);
        check("op0_in_ready", bus.in_ready, 1);
        check("op0_busy", bus.busy, 0);
        bus.in_valid = 1'b0;

        issue("div_m7_2",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
        issue("rem_m7_2",    OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
        issue("div_7_m2",    OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
        issue("rem_7_m2",    OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         DIV_LAT);
        issue("divu_by0",    OP_DIVU,   32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1);
        issue("remu_by0",    OP_REMU,   32'h0000_1234, 32'd0,         32'h0000_1234, 1);
        issue("div_ovf",     OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue("rem_ovf",     OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        issue("remu_100_7",  OP_REMU,   32'd100,       32'd7,         32'd2,         DIV_LAT);
        issue("mulh_min",    OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        issue("mulhsu_m1",   OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        issue("mulhu_max",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        issue("mul_3_m1",    OP_MUL,    32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFD, MUL_LAT);
        issue("multi_bit",   OP_MUL | OP_DIV, 32'd6,   32'd7,         32'd42,        MUL_LAT);
        drain();

        // Backpressure: result must hold while out_ready is low.
        bus.out_ready = 1'b0;
        issue("hold_divu", OP_DIVU, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1);
        t = 0;
        while (!bus.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) timeout("hold_wait");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_result", bus.result_o, 32'hFFFF_FFFF);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_idle", bus.in_ready, 1);
        check("hold_release_valid", bus.out_valid, 0);
        drain();

        // Flush ten cycles into a divide: no result may appear.
        start(OP_DIV, 32'd1000, 32'd3, ac);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_in_ready", bus.in_ready, 1);
        check("flush_busy", bus.busy, 0);
        check("flush_valid", bus.out_valid, 0);
        repeat (40) @(negedge clk);
        check("flush_no_result", bus.out_valid, 0);
        issue("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);
        drain();

        // Asynchronous reset mid-CALC, between clock edges.
        start(OP_DIVU, 32'd999, 32'd9, ac);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_busy", bus.busy, 0);
        check("arst_valid", bus.out_valid, 0);
        check("arst_result", bus.result_o, 0);
        @(negedge clk);
        rst = 1'b0;
        issue("post_rst_mul", OP_MUL, 32'd6, 32'd7, 32'd42, MUL_LAT);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
